// File: rtl/btn_pkg.sv
// btn_pkg: shared types and constants for the button debouncer.
// Holds channel state encoding, default timing and board button indices.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_e;

  localparam int ST_DEF = 2;
  localparam int RD_DEF = 10;
  localparam int RR_DEF = 4;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

endpackage

// File: rtl/btn_debounce_chan.sv
// debounce_chan: one button channel (2-FF sync, tick FSM, auto-repeat).
// In: clk_24M, reset, tick_i, raw_i. Out: level_o, press_o, release_o, repeat_o.
module debounce_chan
  import btn_pkg::*;
#(
  parameter int STABLE_TICKS = ST_DEF,
  parameter int REPEAT_DELAY = RD_DEF,
  parameter int REPEAT_RATE  = RR_DEF
) (
  input  logic clk_24M,
  input  logic reset,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int MAXR = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int HW = $clog2(MAXR + 1);

  logic          sync_q, s_q;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [HW-1:0] hold_q, hold_d, hold_inc, target;
  logic          later_q, later_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rpt_q, rpt_d;

  assign cnt_inc  = cnt_q + 1'b1;
  assign hold_inc = hold_q + 1'b1;
  // later_q is set once the first (long) repeat interval has elapsed
  assign target   = later_q ? HW'(REPEAT_RATE) : HW'(REPEAT_DELAY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    later_d = later_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    if (tick_i) begin
      unique case (state_q)
        IDLE: begin
          if (s_q) begin
            if (STABLE_TICKS == 1) begin
              state_d = HELD;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = CW'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (!s_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == CW'(STABLE_TICKS)) begin
            state_d = HELD;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          if (!s_q) begin
            if (STABLE_TICKS == 1) begin
              state_d = IDLE;
              cnt_d   = '0;
              rel_d   = 1'b1;
            end else begin
              state_d = RELEASE_WAIT;
              cnt_d   = CW'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          if (s_q) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_inc == CW'(STABLE_TICKS)) begin
            state_d = IDLE;
            cnt_d   = '0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      // Repeat never coincides with release: IDLE entry wins.
      if (state_d == IDLE) begin
        hold_d  = '0;
        later_d = 1'b0;
      end else if (state_d == HELD && state_q != HELD) begin
        hold_d = '0;
      end else if (level_q) begin
        if (hold_inc == target) begin
          hold_d  = '0;
          later_d = 1'b1;
          rpt_d   = 1'b1;
        end else begin
          hold_d = hold_inc;
        end
      end
    end
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk_24M) begin
    if (reset) begin
      sync_q  <= 1'b0;
      s_q     <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      later_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync_q  <= raw_i;
      s_q     <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      later_q <= later_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign repeat_o  = rpt_q;

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: N_BTN independent tick-based button debouncers.
// In: clk_24M, reset, tick, btn_raw. Out: btn_level/press/release/repeat.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN        = 5,
  parameter int STABLE_TICKS = ST_DEF,
  parameter int REPEAT_DELAY = RD_DEF,
  parameter int REPEAT_RATE  = RR_DEF
) (
  input  logic             clk_24M,
  input  logic             reset,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_chan (
      .clk_24M  (clk_24M),
      .reset    (reset),
      .tick_i   (tick),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .repeat_o (btn_repeat[i])
    );
  end

endmodule
